// File: rtl/sha256_stream_core_if.sv
// Block-in / digest-out stream bundle for sha256_stream_core.
// valid/ready: a block transfers on a rising edge with blockValid && blockReady; a digest on digestValid && digestReady.
interface sha256_stream_core_if;
    logic [511:0] blockIn;
    logic         blockValid;
    logic         blockReady;
    logic         lastBlock;
    logic         useMidstate;
    logic [255:0] midstateIn;
    logic [255:0] digest;
    logic         digestValid;
    logic         digestReady;
    logic         busy;
    logic [1:0]   dbg_state;

    modport master (
        output blockIn, blockValid, lastBlock, useMidstate, midstateIn, digestReady,
        input  blockReady, digest, digestValid, busy, dbg_state
    );

    modport slave (
        input  blockIn, blockValid, lastBlock, useMidstate, midstateIn, digestReady,
        output blockReady, digest, digestValid, busy, dbg_state
    );
endinterface

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 core: one pre-padded 512-bit block per transfer, chaining across blocks,
// ROUNDS_PER_CYCLE compression rounds per clock with a rolling 16-word schedule window.
module sha256_stream_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic                 clk,
    input logic                 n_rst,
    sha256_stream_core_if.slave core_if
);

    generate
        if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
            $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ROUNDS, FINAL, DONE} state_t;
    typedef logic [0:7][31:0]  vars_t;
    typedef logic [0:15][31:0] win_t;
    typedef logic [0:19][31:0] ext_t;

    localparam logic [5:0] RPC_STEP = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] LAST_RND = 6'(64 - ROUNDS_PER_CYCLE);

    localparam vars_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Window words 0..15 are W[t..t+15]; 16..19 are the next words the window will shift in.
    function automatic ext_t extend(input win_t w);
        ext_t x;
        for (int i = 0; i < 16; i++) x[i] = w[i];
        for (int i = 16; i < 20; i++) x[i] = ssig1(x[i-2]) + x[i-7] + ssig0(x[i-15]) + x[i-16];
        return x;
    endfunction

    function automatic vars_t run_rounds(input vars_t v_in, input ext_t x, input logic [5:0] t0);
        vars_t       v;
        logic [31:0] t1;
        logic [31:0] t2;
        v = v_in;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t0 + 6'(r)] + x[r];
            t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v  = {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
        end
        return v;
    endfunction

    function automatic vars_t add_vars(input vars_t p, input vars_t q);
        vars_t s;
        for (int i = 0; i < 8; i++) s[i] = p[i] + q[i];
        return s;
    endfunction

    state_t       state_q, state_d;
    logic         open_q, open_d;
    logic         last_q, last_d;
    vars_t        h_q, h_d;
    vars_t        v_q, v_d;
    win_t         w_q, w_d;
    logic [5:0]   rnd_q, rnd_d;
    logic [255:0] digest_q, digest_d;
    logic         dvalid_q, dvalid_d;

    logic  ready;
    logic  accept;
    vars_t seed;
    ext_t  sched;
    vars_t rounds_v;
    vars_t h_sum;

    // Gated by n_rst so nothing is offered while reset is held.
    assign ready    = (state_q == IDLE) && n_rst;
    assign accept   = core_if.blockValid && ready;
    assign seed     = core_if.useMidstate ? core_if.midstateIn : IV;
    assign sched    = extend(w_q);
    assign rounds_v = run_rounds(v_q, sched, rnd_q);
    assign h_sum    = add_vars(h_q, v_q);

    always_comb begin
        state_d  = state_q;
        open_d   = open_q;
        last_d   = last_q;
        h_d      = h_q;
        v_d      = v_q;
        w_d      = w_q;
        rnd_d    = rnd_q;
        digest_d = digest_q;
        dvalid_d = dvalid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    w_d     = core_if.blockIn;
                    last_d  = core_if.lastBlock;
                    rnd_d   = '0;
                    open_d  = 1'b1;
                    state_d = ROUNDS;
                    // A first block seeds H as well, so FINAL adds the same value it started from.
                    if (open_q) begin
                        v_d = h_q;
                    end else begin
                        h_d = seed;
                        v_d = seed;
                    end
                end
            end
            ROUNDS: begin
                v_d = rounds_v;
                for (int i = 0; i < 16; i++) w_d[i] = sched[i + ROUNDS_PER_CYCLE];
                rnd_d = rnd_q + RPC_STEP;
                if (rnd_q == LAST_RND) state_d = FINAL;
            end
            FINAL: begin
                h_d = h_sum;
                if (last_q) begin
                    digest_d = h_sum;
                    dvalid_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (core_if.digestReady) begin
                    dvalid_d = 1'b0;
                    open_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            open_q   <= 1'b0;
            last_q   <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            w_q      <= '0;
            rnd_q    <= '0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            open_q   <= open_d;
            last_q   <= last_d;
            h_q      <= h_d;
            v_q      <= v_d;
            w_q      <= w_d;
            rnd_q    <= rnd_d;
            digest_q <= digest_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign core_if.blockReady  = ready;
    assign core_if.busy        = (state_q != IDLE);
    assign core_if.digest      = digest_q;
    assign core_if.digestValid = dvalid_q;
    assign core_if.dbg_state   = state_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: three instances (1, 2 and 4 rounds per cycle) checked against
// FIPS 180-4 vectors and a plain-arithmetic SHA-256 reference model on random messages.
module tb_sha256_stream_core;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [511:0] blk = '0;
    logic         last = 1'b0;
    logic         usem = 1'b0;
    logic [255:0] mid = '0;
    logic [2:0]   bval = '0;
    logic [2:0]   dready = '0;
    logic [255:0] dig [3];
    logic [2:0]   dvalid;
    logic [2:0]   bready;
    logic [2:0]   busy;

    sha256_stream_core_if if_r1 ();
    sha256_stream_core_if if_r2 ();
    sha256_stream_core_if if_r4 ();

    assign if_r1.blockIn = blk;  assign if_r2.blockIn = blk;  assign if_r4.blockIn = blk;
    assign if_r1.lastBlock = last;  assign if_r2.lastBlock = last;  assign if_r4.lastBlock = last;
    assign if_r1.useMidstate = usem;  assign if_r2.useMidstate = usem;  assign if_r4.useMidstate = usem;
    assign if_r1.midstateIn = mid;  assign if_r2.midstateIn = mid;  assign if_r4.midstateIn = mid;
    assign if_r1.blockValid = bval[0];  assign if_r2.blockValid = bval[1];  assign if_r4.blockValid = bval[2];
    assign if_r1.digestReady = dready[0];  assign if_r2.digestReady = dready[1];  assign if_r4.digestReady = dready[2];
    assign dig[0] = if_r1.digest;  assign dig[1] = if_r2.digest;  assign dig[2] = if_r4.digest;
    assign dvalid = {if_r4.digestValid, if_r2.digestValid, if_r1.digestValid};
    assign bready = {if_r4.blockReady, if_r2.blockReady, if_r1.blockReady};
    assign busy   = {if_r4.busy, if_r2.busy, if_r1.busy};

    sha256_stream_core #(.ROUNDS_PER_CYCLE(1)) dut_r1 (.clk(clk), .n_rst(n_rst), .core_if(if_r1.slave));
    sha256_stream_core #(.ROUNDS_PER_CYCLE(2)) dut_r2 (.clk(clk), .n_rst(n_rst), .core_if(if_r2.slave));
    sha256_stream_core #(.ROUNDS_PER_CYCLE(4)) dut_r4 (.clk(clk), .n_rst(n_rst), .core_if(if_r4.slave));

    localparam logic [255:0] IV_M    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};

    localparam logic [31:0] KM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [511:0] b);
        logic [31:0]  w [64];
        logic [31:0]  hh [8];
        logic [31:0]  s [8];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [255:0] res;
        for (int i = 0; i < 8; i++) begin
            hh[i] = hin[255 - 32*i -: 32];
            s[i]  = hh[i];
        end
        for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KM[t] + w[t];
            t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            for (int j = 7; j > 0; j--) s[j] = s[j-1];
            s[4] = s[4] + t1;
            s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hh[i] + s[i];
        return res;
    endfunction

    task automatic pad_msg(input logic [7:0] msg[$], output logic [511:0] blocks_o[$]);
        logic [7:0]   q[$];
        logic [63:0]  bitlen;
        logic [511:0] b;
        q = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        for (int i = 7; i >= 0; i--) q.push_back(bitlen[8*i +: 8]);
        blocks_o = {};
        for (int n = 0; n < q.size() / 64; n++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = q[64*n + j];
            blocks_o.push_back(b);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int rpc_of(input int k);
        return 1 << k;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic present(input int k, input logic [511:0] b, input logic l, input logic u, input logic [255:0] m);
        int n;
        n = 0;
        while (!bready[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bready[k] !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout k=%0d got blockReady=%b want 1", k, bready[k]);
        end
        blk = b; last = l; usem = u; mid = m;
        bval[k] = 1'b1;
        @(posedge clk);
        #1;
        bval[k] = 1'b0;
        blk = rand512(); last = 1'($urandom_range(0, 1)); usem = 1'($urandom_range(0, 1)); mid = rand256();
    endtask

    // Counts edges after the acceptance edge until digestValid (or blockReady) shows up.
    task automatic wait_result(input int k, input bit for_ready, output int lat);
        bit seen;
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            seen = for_ready ? bready[k] : dvalid[k];
            dready[k] = (lat < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        dready[k] = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL result_timeout k=%0d got no %s within %0d edges want it", k, for_ready ? "blockReady" : "digestValid", lat);
        end
    endtask

    task automatic take_digest(input int k);
        dready[k] = 1'b1;
        @(posedge clk);
        #1;
        dready[k] = 1'b0;
        checks++;
        if (dvalid[k] !== 1'b0 || busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL take_digest k=%0d got digestValid=%b busy=%b want 0 0", k, dvalid[k], busy[k]);
        end
        @(negedge clk);
    endtask

    task automatic run_msg(input int k, input logic [511:0] blocks[$], input logic u, input logic [255:0] m,
                           output logic [255:0] d, output int lat);
        bit is_last;
        for (int i = 0; i < blocks.size(); i++) begin
            is_last = (i == blocks.size() - 1);
            present(k, blocks[i], is_last, (i == 0) ? u : 1'($urandom_range(0, 1)), (i == 0) ? m : rand256());
            wait_result(k, !is_last, lat);
            if (!is_last) begin
                checks++;
                if (lat != 64 / rpc_of(k) + 1) begin
                    errors++;
                    $display("FAIL ready_after_final k=%0d got %0d edges want %0d", k, lat, 64 / rpc_of(k) + 1);
                end
            end
        end
        d = dig[k];
        take_digest(k);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bready[k] !== 1'b0 || dvalid[k] !== 1'b0 || busy[k] !== 1'b0 || dig[k] !== 256'h0) begin
                errors++;
                $display("FAIL reset_values k=%0d got ready=%b valid=%b busy=%b digest=%h want 0 0 0 0",
                         k, bready[k], dvalid[k], busy[k], dig[k]);
            end
        end
    endtask

    task automatic test_empty();
        int lat;
        // Block offered together with reset release: must be taken on the very next edge.
        blk = B_EMPTY; last = 1'b1; usem = 1'b0; mid = rand256();
        bval[0] = 1'b1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        bval[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_accept got busy=%b want 1", busy[0]);
        end
        wait_result(0, 1'b0, lat);
        checks++;
        if (lat != 65) begin
            errors++;
            $display("FAIL empty_latency got %0d want 65", lat);
        end
        checks++;
        if (dig[0] !== D_EMPTY) begin
            errors++;
            $display("FAIL empty_digest got %h want %h", dig[0], D_EMPTY);
        end
        take_digest(0);
    endtask

    task automatic test_abc();
        logic [255:0] d;
        int           lat;
        for (int k = 0; k < 3; k++) begin
            run_msg(k, '{B_ABC}, 1'b0, rand256(), d, lat);
            checks++;
            if (d !== D_ABC) begin
                errors++;
                $display("FAIL abc_digest k=%0d got %h want %h", k, d, D_ABC);
            end
            checks++;
            if (lat != 64 / rpc_of(k) + 1) begin
                errors++;
                $display("FAIL abc_latency k=%0d got %0d want %0d", k, lat, 64 / rpc_of(k) + 1);
            end
        end
    endtask

    task automatic two_block_msg(output logic [511:0] blocks[$]);
        string      s;
        logic [7:0] q[$];
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        pad_msg(q, blocks);
    endtask

    task automatic test_two_block();
        logic [511:0] blocks[$];
        logic [255:0] d;
        int           lat;
        two_block_msg(blocks);
        for (int k = 0; k < 3; k += 2) begin
            run_msg(k, blocks, 1'b0, rand256(), d, lat);
            checks++;
            if (d !== D_TWO) begin
                errors++;
                $display("FAIL two_block_digest k=%0d got %h want %h", k, d, D_TWO);
            end
        end
    endtask

    task automatic test_midstate();
        logic [511:0] blocks[$];
        logic [255:0] m;
        logic [255:0] d;
        int           lat;
        two_block_msg(blocks);
        run_msg(0, '{blocks[0]}, 1'b0, rand256(), m, lat);
        checks++;
        if (m !== model_compress(IV_M, blocks[0])) begin
            errors++;
            $display("FAIL midstate_value got %h want %h", m, model_compress(IV_M, blocks[0]));
        end
        run_msg(0, '{blocks[1]}, 1'b1, m, d, lat);
        checks++;
        if (d !== D_TWO) begin
            errors++;
            $display("FAIL midstate_digest got %h want %h", d, D_TWO);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        present(0, B_ABC, 1'b1, 1'b0, rand256());
        wait_result(0, 1'b0, lat);
        for (int c = 0; c < 20; c++) begin
            blk = rand512(); last = 1'($urandom_range(0, 1));
            bval[0] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checks++;
            if (dig[0] !== D_ABC || dvalid[0] !== 1'b1 || bready[0] !== 1'b0 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold cycle=%0d got digest=%h valid=%b ready=%b busy=%b want %h 1 0 1",
                         c, dig[0], dvalid[0], bready[0], busy[0], D_ABC);
            end
        end
        bval[0] = 1'b0;
        take_digest(0);
    endtask

    task automatic test_reset_mid();
        logic [511:0] blocks[$];
        logic [255:0] d;
        int           lat;
        two_block_msg(blocks);
        present(1, B_ABC, 1'b1, 1'b0, rand256());
        wait_result(1, 1'b0, lat);
        present(0, blocks[0], 1'b0, 1'b0, rand256());
        wait_result(0, 1'b1, lat);
        present(0, blocks[1], 1'b1, 1'b0, rand256());
        repeat (10) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bready[k] !== 1'b0 || dvalid[k] !== 1'b0 || busy[k] !== 1'b0 || dig[k] !== 256'h0) begin
                errors++;
                $display("FAIL reset_mid k=%0d got ready=%b valid=%b busy=%b digest=%h want 0 0 0 0",
                         k, bready[k], dvalid[k], busy[k], dig[k]);
            end
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            run_msg(k, '{B_ABC}, 1'b0, rand256(), d, lat);
            checks++;
            if (d !== D_ABC) begin
                errors++;
                $display("FAIL abc_after_reset k=%0d got %h want %h", k, d, D_ABC);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]   msg[$];
        logic [511:0] blocks[$];
        logic [255:0] exp_h;
        logic [255:0] m;
        logic [255:0] d;
        logic         u;
        int           k;
        int           len;
        int           lat;
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(0, 2);
            len = $urandom_range(0, 119);
            u = 1'($urandom_range(0, 1));
            m = rand256();
            msg.delete();
            for (int j = 0; j < len; j++) msg.push_back(8'($urandom));
            pad_msg(msg, blocks);
            exp_h = u ? m : IV_M;
            foreach (blocks[j]) exp_h = model_compress(exp_h, blocks[j]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_msg(k, blocks, u, m, d, lat);
            checks++;
            if (d !== exp_h) begin
                errors++;
                $display("FAIL random_digest it=%0d k=%0d len=%0d mid=%b got %h want %h", it, k, len, u, d, exp_h);
            end
            checks++;
            if (lat != 64 / rpc_of(k) + 1) begin
                errors++;
                $display("FAIL random_latency it=%0d k=%0d got %0d want %0d", it, k, lat, 64 / rpc_of(k) + 1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_two_block();
        test_midstate();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_stream_core.md
SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, giving compression rounds per clock; legal values are 1, 2 and 4, and any other value SHALL stop elaboration.
REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- blockIn  input  512  pre-padded message block, big-endian, word 0 in bits [511:480].
- blockValid  input  1  blockIn is valid.
- blockReady  output  1  core accepts a block this cycle.
- lastBlock  input  1  sampled with blockIn; this is the final block of the message.
- useMidstate  input  1  sampled with the first block of a message; seed the chaining value from midstateIn instead of the IV.
- midstateIn  input  256  external chaining value, H0 in bits [255:224].
- digest  output  256  final hash, H0 in bits [255:224].
- digestValid  output  1  digest is valid.
- digestReady  input  1  consumer takes the digest.
- busy  output  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement the SHA-256 compression function per FIPS 180-4; all additions are modulo 2^32.
REQ-004 SHALL use the states IDLE, ROUNDS, FINAL and DONE.
REQ-005 Acceptance SHALL be the rising edge where blockValid=1 and blockReady=1.
REQ-006 blockReady SHALL be 1 only in IDLE.
REQ-007 On acceptance the core SHALL capture blockIn into the message-schedule window and capture lastBlock.
REQ-008 On acceptance the working variables a..h SHALL load from the chaining value:
- IV, if this is the first block and useMidstate=0;
- midstateIn, if this is the first block and useMidstate=1;
- the retained chaining value H, otherwise.
The state SHALL go to ROUNDS.
REQ-009 ROUNDS SHALL last exactly 64/ROUNDS_PER_CYCLE cycles and execute ROUNDS_PER_CYCLE consecutive rounds per cycle.
- The round counter SHALL count 0..63 in steps of ROUNDS_PER_CYCLE.
- W[t] for t>=16 SHALL come from a rolling 16-word window with no 64-word store.
REQ-010 FINAL SHALL last one cycle and set H := H + {a..h} per word.
REQ-011 From FINAL:
- lastBlock=0: go to IDLE with H retained as the chaining value for the next block, and the message stays open.
- lastBlock=1: go to DONE with digest=H and digestValid=1.
REQ-012 digestValid SHALL rise on edge 64/ROUNDS_PER_CYCLE+1 after acceptance (65 edges for ROUNDS_PER_CYCLE=1, 17 for 4).
REQ-013 In DONE, digest and digestValid SHALL hold stable until an edge with digestReady=1. That edge SHALL:
- clear digestValid;
- close the message, so the next block is a first block;
- move the state to IDLE.
REQ-014 blockValid outside IDLE SHALL be ignored and have no effect.
REQ-015 blockIn, lastBlock, useMidstate and midstateIn SHALL be don't-care except on the acceptance edge; midstateIn SHALL be sampled only on that edge.
REQ-016 useMidstate on a non-first block SHALL be ignored.
REQ-017 digestReady outside DONE SHALL be ignored.

Reset
REQ-018 n_rst=0 SHALL asynchronously force:
- state=IDLE, with the message closed;
- digestValid=0, digest=0, busy=0;
- H, a..h, the schedule window and the round counter all 0.
While n_rst=0, blockReady SHALL be 0.
REQ-019 Reset asserted in any state mid-message SHALL abandon the message. After release the first accepted block SHALL be a first block.
REQ-020 The first acceptance SHALL be possible on the first rising edge after n_rst is released.

Verification
REQ-021 Empty message: blockIn = 0x80000000 followed by 480 zero bits, lastBlock=1, useMidstate=0 -> digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, with digestValid rising exactly 65 edges after acceptance (ROUNDS_PER_CYCLE=1).
REQ-022 "abc": blockIn = 0x61626380, zeros, last word 0x00000018, lastBlock=1 -> digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, checked at ROUNDS_PER_CYCLE=1, 2 and 4 with latency 65, 33 and 17 edges respectively.
REQ-023 Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", padded and sent with lastBlock=0 then lastBlock=1 -> digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; blockReady=1 in the cycle after FINAL of block 1.
REQ-024 Midstate: run block 1 of REQ-023 alone with lastBlock=1 to obtain M; then send block 2 with useMidstate=1, midstateIn=M, lastBlock=1 -> digest equals the REQ-023 value.
REQ-025 Backpressure and reset:
- Hold digestReady=0 for 20 cycles in DONE and pulse blockValid meanwhile -> digest stable, blockReady=0, block ignored.
- Assert n_rst mid-ROUNDS -> all outputs 0 immediately; a following REQ-022 run is still correct.
